// File: rtl/reg_file_pkg.sv
// Shared register-file constants and the default register-number type.
// Pure declarations; no logic, no latency, no backpressure.
package reg_file_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// Read, writeback and issue bundle between the pipeline (master) and the register file (slave).
// Wires only: read results are combinational, and the strobes have no backpressure.
interface reg_file_sb_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              hazard;
    logic [ADDR_W:0]   num_busy;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, hazard, num_busy
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, hazard, num_busy
    );
endinterface

// File: rtl/reg_sb.sv
// Scoreboard of pending results: the busy bits and their population count change 1 cycle after a strobe.
// No backpressure; a same-cycle writeback hides a busy bit on the read ports.
module reg_sb
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic [ADDR_W:0]   num_busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [ADDR_W:0]  num_busy_q;
    logic             set_ok;
    logic             inc;
    logic             dec;

    // Set is applied after clear so that an issue colliding with a writeback keeps the bit.
    // The counter follows only real 0->1 and 1->0 transitions, so it always equals popcount(busy).
    always_comb begin
        set_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));
        busy_d = busy_q;
        if (wr_en)  busy_d[wr_addr]  = 1'b0;
        if (set_ok) busy_d[iss_addr] = 1'b1;
        inc = set_ok && !busy_q[iss_addr];
        dec = wr_en && busy_q[wr_addr] && !(set_ok && (iss_addr == wr_addr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            num_busy_q <= '0;
        end else begin
            busy_q     <= busy_d;
            num_busy_q <= num_busy_q + CNT_W'(inc) - CNT_W'(dec);
        end
    end

    assign rd_busy1 = busy_q[rd_addr1] && !(wr_en && (wr_addr == rd_addr1));
    assign rd_busy2 = busy_q[rd_addr2] && !(wr_en && (wr_addr == rd_addr2));
    assign num_busy = num_busy_q;
endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with scoreboard; reads are combinational with writeback bypass, and writes land at the next edge.
// No backpressure: the pipeline uses hazard to stall itself.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_ok;
    logic              busy1;
    logic              busy2;

    assign wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Priority: hardwired zero, then same-cycle writeback, then stored value.
    always_comb begin
        bus.rd_data1 = regs[bus.rd_addr1];
        bus.rd_data2 = regs[bus.rd_addr2];
        if (bus.wr_en && (bus.wr_addr == bus.rd_addr1)) bus.rd_data1 = bus.wr_data;
        if (bus.wr_en && (bus.wr_addr == bus.rd_addr2)) bus.rd_data2 = bus.wr_data;
        if ((ZERO_REG != 0) && (bus.rd_addr1 == '0)) bus.rd_data1 = '0;
        if ((ZERO_REG != 0) && (bus.rd_addr2 == '0)) bus.rd_data2 = '0;
    end

    reg_sb #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .rd_addr1 (bus.rd_addr1),
        .rd_addr2 (bus.rd_addr2),
        .rd_busy1 (busy1),
        .rd_busy2 (busy2),
        .num_busy (bus.num_busy)
    );

    assign bus.rd_busy1 = busy1;
    assign bus.rd_busy2 = busy2;
    assign bus.hazard   = busy1 | busy2;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus random traffic against an array/popcount model.
// Inputs change 1 time unit after posedge; outputs are sampled before the next posedge.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 1 << AW;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [DW-1:0] m_reg  [NR];
    bit            m_busy [NR];

    reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input reg_addr_t a);
        if (a == 0) return '0;
        if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input reg_addr_t a);
        return m_busy[a] && !(bus.wr_en && bus.wr_addr == a);
    endfunction

    function automatic int popcount();
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic b1, b2;
        b1 = exp_busy(bus.rd_addr1);
        b2 = exp_busy(bus.rd_addr2);
        chk({tag, ".rd_data1"}, 64'(bus.rd_data1), 64'(exp_rd(bus.rd_addr1)));
        chk({tag, ".rd_data2"}, 64'(bus.rd_data2), 64'(exp_rd(bus.rd_addr2)));
        chk({tag, ".rd_busy1"}, 64'(bus.rd_busy1), 64'(b1));
        chk({tag, ".rd_busy2"}, 64'(bus.rd_busy2), 64'(b2));
        chk({tag, ".hazard"},   64'(bus.hazard),   64'(b1 | b2));
        chk({tag, ".num_busy"}, 64'(bus.num_busy), 64'(popcount()));
    endtask

    // One clock: check pre-edge outputs, take the edge, apply the architectural rules to the model.
    task automatic step(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        if (bus.wr_en && bus.wr_addr != 0) m_reg[bus.wr_addr] = bus.wr_data;
        if (bus.wr_en) m_busy[bus.wr_addr] = 1'b0;
        if (bus.iss_en && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_clear();
        idle_inputs();
        bus.rd_addr1 = 5'd5;
        bus.rd_addr2 = 5'd6;
        rst_n = 1'b0;

        // Reset: state clear, bypass still visible, strobes ignored
        #1;
        chk("rst.num_busy", 64'(bus.num_busy), 64'd0);
        chk("rst.hazard",   64'(bus.hazard),   64'd0);
        chk("rst.rd_data1", 64'(bus.rd_data1), 64'd0);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hDEAD_BEEF;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
        bus.rd_addr1 = 5'd3; bus.rd_addr2 = 5'd3;
        #1;
        chk("rst.bypass",   64'(bus.rd_data1), 64'h0000_0000_DEAD_BEEF);
        chk("rst.rd_busy2", 64'(bus.rd_busy2), 64'd0);
        @(posedge clk); #1;
        chk("rst.iss_ignored", 64'(bus.num_busy), 64'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All registers read zero after reset, including r3 written during reset
        for (int i = 1; i < NR; i++) begin
            bus.rd_addr1 = AW'(i);
            bus.rd_addr2 = AW'(NR - i);
            #1;
            chk($sformatf("zero.r%0d", i), 64'(bus.rd_data1), 64'd0);
            chk($sformatf("zero2.r%0d", NR - i), 64'(bus.rd_data2), 64'd0);
        end
        chk("zero.num_busy", 64'(bus.num_busy), 64'd0);
        chk("zero.hazard",   64'(bus.hazard),   64'd0);
        @(posedge clk); #1;

        // Same-cycle bypass, then stored value
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'h0000_00AA; bus.rd_addr1 = 5'd5;
        #1;
        chk("byp.r5", 64'(bus.rd_data1), 64'hAA);
        step("byp");
        idle_inputs();
        #1;
        chk("stored.r5", 64'(bus.rd_data1), 64'hAA);

        // Register 0 is hardwired
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFF_FFFF; bus.rd_addr1 = 5'd0;
        step("r0wr");
        idle_inputs();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        step("r0iss");
        idle_inputs();
        #1;
        chk("r0.rd_data1", 64'(bus.rd_data1), 64'd0);
        chk("r0.num_busy", 64'(bus.num_busy), 64'd0);

        // Issue r3, r7, r3 again; then retire r7
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3; step("iss3");
        bus.iss_addr = 5'd7; step("iss7");
        bus.iss_addr = 5'd3; step("iss3b");
        idle_inputs();
        bus.rd_addr2 = 5'd7;
        #1;
        chk("sb.num_busy2", 64'(bus.num_busy), 64'd2);
        chk("sb.rd_busy2",  64'(bus.rd_busy2), 64'd1);
        chk("sb.hazard",    64'(bus.hazard),   64'd1);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h7777_0007;
        #1;
        chk("sb.hide_busy2", 64'(bus.rd_busy2), 64'd0);
        step("wr7");
        idle_inputs();
        #1;
        chk("sb.num_busy1",  64'(bus.num_busy), 64'd1);
        chk("sb.rd_busy2_0", 64'(bus.rd_busy2), 64'd0);

        // Issue and writeback to the same busy register in one cycle
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9; step("iss9");
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h0909_0909;
        step("coll9");
        idle_inputs();
        bus.rd_addr1 = 5'd9;
        #1;
        chk("coll.rd_busy1", 64'(bus.rd_busy1), 64'd1);
        chk("coll.num_busy", 64'(bus.num_busy), 64'd2);

        // Random traffic, with frequent issue/writeback address collisions
        for (int n = 0; n < 400; n++) begin
            bus.rd_addr1 = AW'($urandom_range(0, NR - 1));
            bus.rd_addr2 = AW'($urandom_range(0, NR - 1));
            bus.iss_en   = ($urandom_range(0, 99) < 45);
            bus.iss_addr = AW'($urandom_range(0, NR - 1));
            bus.wr_en    = ($urandom_range(0, 99) < 45);
            bus.wr_addr  = ($urandom_range(0, 3) == 0) ? bus.iss_addr : AW'($urandom_range(0, NR - 1));
            bus.wr_data  = $urandom;
            if ($urandom_range(0, 3) == 0) bus.rd_addr1 = bus.wr_addr;
            step("rnd");
        end
        idle_inputs();

        // Reset mid-operation
        bus.iss_en = 1'b1; bus.iss_addr = 5'd2; step("iss2");
        bus.iss_addr = 5'd4; step("iss4");
        idle_inputs();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 32'h0000_1234; step("wr10");
        idle_inputs();
        bus.rd_addr1 = 5'd10; bus.rd_addr2 = 5'd2;
        #1;
        chk("pre_rst.r10", 64'(bus.rd_data1), 64'h1234);
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("mid_rst.r10",      64'(bus.rd_data1), 64'd0);
        chk("mid_rst.num_busy", 64'(bus.num_busy), 64'd0);
        chk("mid_rst.hazard",   64'(bus.hazard),   64'd0);
        chk("mid_rst.rd_busy2", 64'(bus.rd_busy2), 64'd0);
        rst_n = 1'b1;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd6;
        step("post_rst_iss6");
        idle_inputs();
        bus.rd_addr1 = 5'd6;
        #1;
        chk("post_rst.num_busy", 64'(bus.num_busy), 64'd1);
        chk("post_rst.rd_busy1", 64'(bus.rd_busy1), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; depth = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 reads 0, ignores writes and is never busy.
REQ-004 clk  input  1: single clock; all state updates on posedge.
REQ-005 rst_n  input  1: reset; asynchronous, active-low.
REQ-006 rd_addr1, rd_addr2  input  ADDR_W each: read port addresses (rs, rt).
REQ-007 rd_data1, rd_data2  output  DATA_W each: read data, combinational.
REQ-008 rd_busy1, rd_busy2  output  1 each: addressed register has a pending (unwritten) result.
REQ-009 wr_en  input  1: writeback strobe.
REQ-010 wr_addr  input  ADDR_W: writeback register number.
REQ-011 wr_data  input  DATA_W: writeback data.
REQ-012 iss_en  input  1: issue strobe; marks iss_addr pending.
REQ-013 iss_addr  input  ADDR_W: destination register of issued instruction.
REQ-014 hazard  output  1: rd_busy1 OR rd_busy2.
REQ-015 num_busy  output  ADDR_W+1: count of registers currently pending.

Function
REQ-016 Write: at posedge, if wr_en and not (ZERO_REG and wr_addr==0), reg[wr_addr] <= wr_data.
REQ-017 Read: rd_dataN = 0 if ZERO_REG and rd_addrN==0; else wr_data if wr_en and wr_addr==rd_addrN (same-cycle bypass); else reg[rd_addrN].
REQ-018 Scoreboard: one busy bit per register, 1-cycle latency from strobe to bit update.
REQ-019 Busy set: iss_en at posedge sets busy[iss_addr] (except register 0 when ZERO_REG).
REQ-020 Busy clear: wr_en at posedge clears busy[wr_addr].
REQ-021 iss_en and wr_en to the same address in the same cycle: set wins; busy stays/becomes 1.
REQ-022 iss_en to an already-busy register: busy stays 1, num_busy unchanged.
REQ-023 wr_en to a non-busy register: data written, busy stays 0, num_busy unchanged.
REQ-024 rd_busyN = busy[rd_addrN] AND NOT (wr_en and wr_addr==rd_addrN); bypassed writeback hides the pending bit in the same cycle.
REQ-025 num_busy next = num_busy + (new set of a 0 bit) - (clear of a 1 bit not simultaneously re-set); never wraps; equals popcount(busy) at every clock edge.
REQ-026 num_busy maximum is 2**ADDR_W - ZERO_REG; width ADDR_W+1 covers it without overflow.

Reset
REQ-027 rst_n low asynchronously clears every register to 0, every busy bit to 0 and num_busy to 0.
REQ-028 While rst_n low, rd_dataN = 0, wr_data bypass still applies combinationally but no state changes; rd_busyN=0, hazard=0.
REQ-029 Reset asserted mid-operation discards pending state; first posedge after rst_n rises honours strobes normally.

Structure
REQ-030 Shared package reg_file_pkg holds default DATA_W/ADDR_W constants and the register-address typedef.
REQ-031 Scoreboard (busy bits, num_busy) is sub-module reg_sb, instantiated once; storage and bypass stay in reg_file_sb.
REQ-032 Storage is a flat register array; no memory macro.

Verification
REQ-033 Reset then read r1..r31 -> all rd_data 0, num_busy 0, hazard 0.
REQ-034 wr_en r5=0x0000_00AA with rd_addr1=5 same cycle -> rd_data1=0xAA before edge; after edge reg read returns 0xAA.
REQ-035 wr_en r0=0xFFFF_FFFF (ZERO_REG=1) -> rd_data of r0 stays 0; iss_en r0 -> num_busy stays 0.
REQ-036 iss r3, iss r7, iss r3 again -> num_busy=2; rd_addr2=7 -> rd_busy2=1, hazard=1; wr r7 -> num_busy=1, rd_busy2=0.
REQ-037 iss_en r9 and wr_en r9 same cycle while busy[9]=1 -> busy[9]=1, num_busy unchanged.
REQ-038 Set busy r2,r4, write r10=0x1234, pulse rst_n low between edges -> immediately reg r10 reads 0, num_busy 0, hazard 0.
